// File: rtl/td4_pkg.sv
// td4_pkg: shared constants and debounce state type for the TD4 input port
package td4_pkg;
    localparam int PORT_W = 4;
    localparam int DB_CYCLES_DEF = 250000;
    localparam int CNT_W_DEF = 18;
    typedef enum logic {STABLE, COUNT} db_state_t;
endpackage

// File: rtl/td4_in_port_if.sv
// td4_in_port_if: switch/tick/clear inputs and conditioned outputs of the input port
interface td4_in_port_if;
    import td4_pkg::*;
    logic [PORT_W-1:0] sw;
    logic [PORT_W-1:0] clr;
    logic [PORT_W-1:0] in_val;
    logic [PORT_W-1:0] rise;
    logic              tick;
    logic              changed;
    modport master (output sw, clr, tick, input in_val, rise, changed);
    modport slave (input sw, clr, tick, output in_val, rise, changed);
endinterface

// File: rtl/td4_debounce_bit.sv
// td4_debounce_bit: two-flop synchronizer plus counter debounce for one switch line
module td4_debounce_bit
    import td4_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable,
    output logic toggle
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
    logic             s1;
    logic             s2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    // entering COUNT already accounts for the first differing sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            toggle <= 1'b0;
            state  <= STABLE;
            cnt    <= '0;
        end else begin
            s1     <= sw;
            s2     <= s1;
            toggle <= 1'b0;
            if (state == STABLE) begin
                if (s2 != stable) begin
                    state <= COUNT;
                    cnt   <= CNT_W'(1);
                end
            end else if (s2 == stable) begin
                state <= STABLE;
                cnt   <= '0;
            end else if (cnt == LAST) begin
                stable <= ~stable;
                toggle <= 1'b1;
                state  <= STABLE;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/td4_in_port.sv
// td4_in_port: debounced, tick-held 4-bit input with sticky rise flags and change strobe
module td4_in_port
    import td4_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic          clk,
    input logic          rst,
    td4_in_port_if.slave port
);
    logic [PORT_W-1:0] stable;
    logic [PORT_W-1:0] tog;
    for (genvar i = 0; i < PORT_W; i++) begin : g_bit
        td4_debounce_bit #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .sw    (port.sw[i]),
            .stable(stable[i]),
            .toggle(tog[i])
        );
    end
    // tog is high together with the new stable value, so tog & stable marks a 0->1 edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port.in_val  <= '0;
            port.rise    <= '0;
            port.changed <= 1'b0;
        end else begin
            port.in_val  <= port.tick ? stable : port.in_val;
            port.rise    <= (port.rise & ~port.clr) | (tog & stable);
            port.changed <= |tog;
        end
    end
endmodule

// File: tb/tb_td4_in_port.sv
// tb_td4_in_port: random and directed stimulus checked against a sample-window model
module tb_td4_in_port;
    import td4_pkg::*;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    td4_in_port_if bus();
    td4_in_port #(.DB_CYCLES(DB), .CNT_W(3)) dut (.clk(clk), .rst(rst), .port(bus.slave));
    always #5 clk = ~clk;

    // swh[j] = sw sampled j+1 edges ago; synchronizer output seen now is swh[1]
    logic [3:0] swh [DB+1];
    logic [3:0] m_st, m_fl, m_in, m_rise;
    logic       m_chg;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j <= DB; j++) swh[j] = '0;
            m_st = '0; m_fl = '0; m_in = '0; m_rise = '0; m_chg = 1'b0;
        end else begin
            logic [3:0] fl;
            fl = '1;
            for (int j = 1; j <= DB; j++) fl &= swh[j] ^ m_st;
            m_in   = bus.tick ? m_st : m_in;
            m_rise = (m_rise & ~bus.clr) | (m_fl & m_st);
            m_chg  = |m_fl;
            m_st   = m_st ^ fl;
            m_fl   = fl;
            for (int j = DB; j > 0; j--) swh[j] = swh[j-1];
            swh[0] = bus.sw;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_in_val", 8'(bus.in_val), 8'(m_in));
        chk("model_rise", 8'(bus.rise), 8'(m_rise));
        chk("model_changed", 8'(bus.changed), 8'(m_chg));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int n;
        logic burst;
        bus.sw = 4'hF; bus.tick = 1'b1; bus.clr = '0;
        step(3);
        chk("rst_in_val", 8'(bus.in_val), 8'h0);
        chk("rst_rise", 8'(bus.rise), 8'h0);
        chk("rst_changed", 8'(bus.changed), 8'h0);
        rst = 1'b1;
        step(6);
        chk("rel_changed_early", 8'(bus.changed), 8'h0);
        chk("rel_rise_early", 8'(bus.rise), 8'h0);
        step(1);
        chk("rel_changed", 8'(bus.changed), 8'h1);
        chk("rel_rise", 8'(bus.rise), 8'hF);
        chk("rel_in_val", 8'(bus.in_val), 8'hF);
        step(1);
        chk("rel_changed_once", 8'(bus.changed), 8'h0);
        // bounce rejection on bit 0
        bus.clr = 4'hF; step(1); bus.clr = '0;
        n = 0;
        bus.sw[0] = 1'b0; step(2); bus.sw[0] = 1'b1; step(2);
        bus.sw[0] = 1'b0; step(2); bus.sw[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n += int'(bus.changed);
        end
        chk("bounce_changed", 8'(n), 8'h0);
        chk("bounce_in_val0", 8'(bus.in_val[0]), 8'h1);
        // clean press on bit 2 with a sparse tick
        bus.sw[2] = 1'b0; step(10);
        bus.clr = 4'hF; bus.tick = 1'b0; step(1); bus.clr = '0;
        bus.sw[2] = 1'b1;
        step(7);
        chk("press_rise2", 8'(bus.rise[2]), 8'h1);
        chk("press_in_val2_hold", 8'(bus.in_val[2]), 8'h0);
        for (int i = 0; i < 16; i++) begin
            bus.tick = (i % 8 == 7);
            step(1);
        end
        bus.tick = 1'b0;
        chk("press_in_val2", 8'(bus.in_val[2]), 8'h1);
        // tick lands on the same edge as the stable[1] update
        bus.sw[1] = 1'b0;
        step(5);
        bus.tick = 1'b1; step(1); bus.tick = 1'b0;
        chk("coinc_in_val1_old", 8'(bus.in_val[1]), 8'h1);
        step(1);
        chk("coinc_changed", 8'(bus.changed), 8'h1);
        chk("coinc_in_val1_hold", 8'(bus.in_val[1]), 8'h1);
        bus.tick = 1'b1; step(1); bus.tick = 1'b0;
        chk("coinc_in_val1_new", 8'(bus.in_val[1]), 8'h0);
        // set/clear collision on bit 3
        bus.sw[3] = 1'b0; step(8);
        bus.sw[3] = 1'b1; bus.clr = 4'b1000;
        step(6);
        chk("coll_rise3_pre", 8'(bus.rise[3]), 8'h0);
        step(1);
        chk("coll_rise3_set", 8'(bus.rise[3]), 8'h1);
        step(1);
        chk("coll_rise3_clr", 8'(bus.rise[3]), 8'h0);
        bus.clr = '0;
        // reset while the bit-1 counter is mid-count
        bus.sw[1] = 1'b1;
        step(4);
        rst = 1'b0; step(1); rst = 1'b1;
        chk("midrst_rise", 8'(bus.rise), 8'h0);
        step(6);
        chk("midrst_rise1_early", 8'(bus.rise[1]), 8'h0);
        step(1);
        chk("midrst_rise1", 8'(bus.rise[1]), 8'h1);
        // random phase: alternating bouncy and quiet stretches
        burst = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) burst = ~burst;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(burst ? 3 : 31) == 0) bus.sw[b] = ~bus.sw[b];
            bus.tick = ($urandom_range(2) == 0);
            bus.clr  = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
            rst      = ($urandom_range(399) != 0);
            step(1);
        end
        rst = 1'b1;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
